mod_if: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the PC register and the IF/ID pipeline register, and drives the instruction memory through a variable-latency request/valid handshake. It feeds `instruction`, `pc` and `valid` to the decode stage, and takes back the decode stage's branch resolution (`taken`, `new_pc`) and the hazard unit's stall. On fetching HLT it stops issuing requests.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 33 +++
 rtl/mod_if.sv | 155 +++++++++++++++
 tb/tb_mod_if.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and constants for the fetch stage
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE  = 4'hF;
    localparam logic [15:0] PC_INC       = 16'd2;

    // Takes only the opcode field so callers decide which word is being decoded.
    function automatic logic is_halt(input logic [3:0] opcode, input logic [3:0] halt_op);
        return opcode == halt_op;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load / hold / flush controls
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc,
    output logic [15:0] instruction,
    output logic [15:0] pc,
    output logic        valid
);

    // Load wins over flush; neither asserted means hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= BUBBLE_INSTR;
            pc          <= 16'h0000;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= load_instr;
            pc          <= load_pc;
            valid       <= 1'b1;
        end else if (flush) begin
            instruction <= BUBBLE_INSTR;
            pc          <= 16'h0000;
            valid       <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_if.sv
// rtl/mod_if.sv - instruction fetch stage: PC, imem handshake, IF/ID register
module mod_if #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        taken,
    input  logic [15:0] new_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic [15:0] pc,
    output logic        valid,
    output logic        halted
);
    import cpu_pkg::*;

    fetch_state_t state, state_next;
    logic [15:0]  pc_reg, pc_next, pc_plus;
    logic         redirect_pending, redirect_pending_next;
    logic [15:0]  redirect_pc, redirect_pc_next;
    logic [15:0]  hold_instr, hold_pc;
    logic         hold_capture;
    logic         ifid_load, ifid_flush;
    logic [15:0]  ifid_instr, ifid_pc;
    logic         data_is_halt, hold_is_halt;

    assign pc_plus      = pc_reg + PC_INC;
    assign data_is_halt = is_halt(imem_data[15:12], HALT_OPCODE);
    assign hold_is_halt = is_halt(hold_instr[15:12], HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg           <= RESET_PC;
            redirect_pending <= 1'b0;
            redirect_pc      <= 16'h0000;
            hold_instr       <= BUBBLE_INSTR;
            hold_pc          <= 16'h0000;
        end else begin
            pc_reg           <= pc_next;
            redirect_pending <= redirect_pending_next;
            redirect_pc      <= redirect_pc_next;
            if (hold_capture) begin
                hold_instr <= imem_data;
                hold_pc    <= pc_plus;
            end
        end
    end

    // Stall dominates taken: a stalled ID has not finalised its branch.
    always_comb begin
        state_next            = state;
        pc_next               = pc_reg;
        redirect_pending_next = redirect_pending;
        redirect_pc_next      = redirect_pc;
        hold_capture          = 1'b0;
        ifid_load             = 1'b0;
        ifid_flush            = 1'b0;
        ifid_instr            = imem_data;
        ifid_pc               = pc_plus;
        case (state)
            FETCH: begin
                if (!stall_in) begin
                    if (taken) begin
                        ifid_flush = 1'b1;
                        pc_next    = new_pc;
                    end else if (imem_valid) begin
                        ifid_load = 1'b1;
                        pc_next   = pc_plus;
                        if (data_is_halt) state_next = HALTED;
                    end else begin
                        ifid_flush = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    if (redirect_pending) begin
                        // Response belongs to the squashed path; the newest target wins.
                        ifid_flush            = !stall_in;
                        pc_next               = (taken && !stall_in) ? new_pc : redirect_pc;
                        redirect_pending_next = 1'b0;
                        state_next            = FETCH;
                    end else if (stall_in) begin
                        hold_capture = 1'b1;
                        state_next   = HOLD;
                    end else if (taken) begin
                        ifid_flush = 1'b1;
                        pc_next    = new_pc;
                        state_next = FETCH;
                    end else begin
                        ifid_load  = 1'b1;
                        pc_next    = pc_plus;
                        state_next = data_is_halt ? HALTED : FETCH;
                    end
                end else if (!stall_in) begin
                    ifid_flush = 1'b1;
                    if (taken) begin
                        redirect_pending_next = 1'b1;
                        redirect_pc_next      = new_pc;
                    end
                end
            end
            HOLD: begin
                if (!stall_in) begin
                    if (taken) begin
                        ifid_flush = 1'b1;
                        pc_next    = new_pc;
                    end else begin
                        ifid_load  = 1'b1;
                        ifid_instr = hold_instr;
                        ifid_pc    = hold_pc;
                        pc_next    = hold_pc;
                    end
                    state_next = (!taken && hold_is_halt) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req  = !rst && (state == FETCH || state == WAIT);
        imem_addr = pc_reg;
        halted    = (state == HALTED);
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .load_instr  (ifid_instr),
        .load_pc     (ifid_pc),
        .instruction (instruction),
        .pc          (pc),
        .valid       (valid)
    );

endmodule

// File: tb/tb_mod_if.sv
// tb/tb_mod_if.sv - self-checking bench for the instruction fetch stage
module tb_mod_if;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        taken;
    logic [15:0] new_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        valid;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [15:0] r_addr;
    logic        r_active   = 1'b0;
    int          r_cnt;
    int          r_lat;
    bit          lat_random = 1'b0;
    bit          miss_armed = 1'b0;
    logic [15:0] miss_addr  = 16'h0000;
    int          miss_lat   = 0;
    bit          halt_en    = 1'b0;
    logic [15:0] halt_addr  = 16'h0000;

    mod_if #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .taken       (taken),
        .new_pc      (new_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .instruction (instruction),
        .pc          (pc),
        .valid       (valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Program image: opcode never HLT except the planted halt word.
    function automatic logic [15:0] word(input logic [15:0] a);
        logic [3:0] op;
        op = a[15:12] ^ a[4:1] ^ a[8:5];
        if (op == 4'hF) op = 4'hE;
        if (halt_en && a == halt_addr) return 16'hF000;
        return {op, a[11:0] ^ 12'h5A3};
    endfunction

    task automatic mem_respond();
        if (!imem_req) begin
            r_active   = 1'b0;
            imem_valid = lat_random ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_data  = 16'($urandom);
        end else begin
            if (!r_active || imem_addr != r_addr) begin
                r_active = 1'b1;
                r_addr   = imem_addr;
                r_cnt    = 0;
                if (miss_armed && imem_addr == miss_addr) begin
                    r_lat      = miss_lat;
                    miss_armed = 1'b0;
                end else begin
                    r_lat = lat_random ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (r_cnt >= r_lat) begin
                imem_valid = 1'b1;
                imem_data  = word(r_addr);
                r_active   = 1'b0;
            end else begin
                imem_valid = 1'b0;
                imem_data  = 16'($urandom);
                r_cnt++;
            end
        end
    endtask

    task automatic drive(input logic s, input logic t, input logic [15:0] np);
        stall_in = s;
        taken    = t;
        new_pc   = np;
        #1;
        mem_respond();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        checks++; if (imem_req !== 1'b0) begin $display("FAIL reset_req_async: got %b expected 0", imem_req); failures++; end
        step();
        step();
        checks++; if (instruction !== 16'h0000) begin $display("FAIL reset_instr: got %h expected 0000", instruction); failures++; end
        checks++; if (pc !== 16'h0000) begin $display("FAIL reset_pc: got %h expected 0000", pc); failures++; end
        checks++; if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", valid); failures++; end
        checks++; if (halted !== 1'b0) begin $display("FAIL reset_halted: got %b expected 0", halted); failures++; end
        checks++; if (imem_req !== 1'b0) begin $display("FAIL reset_req: got %b expected 0", imem_req); failures++; end
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        checks++; if (imem_req !== 1'b1) begin $display("FAIL reset_release_req: got %b expected 1", imem_req); failures++; end
        checks++; if (imem_addr !== 16'h0000) begin $display("FAIL reset_addr: got %h expected 0000", imem_addr); failures++; end
    endtask

    task automatic test_hits();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'h0000);
            checks++; if (imem_addr !== 16'(2 * i)) begin $display("FAIL hit_addr[%0d]: got %h expected %h", i, imem_addr, 16'(2 * i)); failures++; end
            step();
            checks++; if (instruction !== word(16'(2 * i))) begin $display("FAIL hit_instr[%0d]: got %h expected %h", i, instruction, word(16'(2 * i))); failures++; end
            checks++; if (pc !== 16'(2 * i + 2)) begin $display("FAIL hit_pc[%0d]: got %h expected %h", i, pc, 16'(2 * i + 2)); failures++; end
            checks++; if (valid !== 1'b1) begin $display("FAIL hit_valid[%0d]: got %b expected 1", i, valid); failures++; end
        end
    endtask

    task automatic test_miss();
        do_reset();
        miss_addr = 16'h0004; miss_lat = 3; miss_armed = 1'b1;
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 16'h0000); step(); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 16'h0000);
            checks++; if (imem_addr !== 16'h0004 || imem_req !== 1'b1) begin $display("FAIL miss_addr[%0d]: got req=%b addr=%h expected req=1 addr=0004", k, imem_req, imem_addr); failures++; end
            step();
            if (k < 3) begin
                checks++; if (valid !== 1'b0 || instruction !== 16'h0000) begin $display("FAIL miss_bubble[%0d]: got valid=%b instr=%h expected 0/0000", k, valid, instruction); failures++; end
            end else begin
                checks++; if (valid !== 1'b1 || instruction !== word(16'h0004) || pc !== 16'h0006) begin $display("FAIL miss_word: got %b/%h/%h expected 1/%h/0006", valid, instruction, pc, word(16'h0004)); failures++; end
            end
        end
    endtask

    task automatic test_taken_hit();
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b0, 16'h0000); step(); end
        drive(1'b0, 1'b1, 16'h0040);
        checks++; if (imem_addr !== 16'h0008) begin $display("FAIL tkh_addr: got %h expected 0008", imem_addr); failures++; end
        step();
        checks++; if (valid !== 1'b0 || instruction !== 16'h0000) begin $display("FAIL tkh_squash: got %b/%h expected 0/0000", valid, instruction); failures++; end
        checks++; if (imem_addr !== 16'h0040) begin $display("FAIL tkh_target: got %h expected 0040", imem_addr); failures++; end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (valid !== 1'b1 || instruction !== word(16'h0040) || pc !== 16'h0042) begin $display("FAIL tkh_word: got %b/%h/%h expected 1/%h/0042", valid, instruction, pc, word(16'h0040)); failures++; end
    endtask

    task automatic test_taken_miss();
        do_reset();
        miss_addr = 16'h0000; miss_lat = 3; miss_armed = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b0, 1'b1, 16'h0040);
        step();
        checks++; if (valid !== 1'b0) begin $display("FAIL tkm_bubble: got %b expected 0", valid); failures++; end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 16'h0000);
            checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin $display("FAIL tkm_hold_addr[%0d]: got %b/%h expected 1/0000", k, imem_req, imem_addr); failures++; end
            step();
        end
        checks++; if (valid !== 1'b0) begin $display("FAIL tkm_dropped: got valid=%b expected 0", valid); failures++; end
        checks++; if (imem_addr !== 16'h0040) begin $display("FAIL tkm_target: got %h expected 0040", imem_addr); failures++; end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (valid !== 1'b1 || instruction !== word(16'h0040) || pc !== 16'h0042) begin $display("FAIL tkm_word: got %b/%h/%h expected 1/%h/0042", valid, instruction, pc, word(16'h0040)); failures++; end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b0, 1'b0, 16'h0000);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 16'h0000);
            step();
            checks++; if (instruction !== word(16'h0000) || pc !== 16'h0002 || valid !== 1'b1 || imem_addr !== 16'h0002) begin $display("FAIL stall_freeze[%0d]: got %h/%h/%b addr=%h expected %h/0002/1 addr=0002", k, instruction, pc, valid, imem_addr, word(16'h0000)); failures++; end
        end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (instruction !== word(16'h0002) || pc !== 16'h0004 || valid !== 1'b1) begin $display("FAIL stall_release: got %h/%h/%b expected %h/0004/1", instruction, pc, valid, word(16'h0002)); failures++; end
        miss_addr = 16'h0004; miss_lat = 2; miss_armed = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b0, 1'b0, 16'h0000);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 16'h0000);
            step();
            checks++; if (imem_req !== 1'b0 || valid !== 1'b0) begin $display("FAIL stall_hold[%0d]: got req=%b valid=%b expected 0/0", k, imem_req, valid); failures++; end
        end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (instruction !== word(16'h0004) || pc !== 16'h0006 || valid !== 1'b1) begin $display("FAIL stall_hold_word: got %h/%h/%b expected %h/0006/1", instruction, pc, valid, word(16'h0004)); failures++; end
        checks++; if (imem_addr !== 16'h0006 || imem_req !== 1'b1) begin $display("FAIL stall_hold_next: got %b/%h expected 1/0006", imem_req, imem_addr); failures++; end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (instruction !== word(16'h0006) || pc !== 16'h0008) begin $display("FAIL stall_after: got %h/%h expected %h/0008", instruction, pc, word(16'h0006)); failures++; end
    endtask

    task automatic test_stall_taken();
        do_reset();
        drive(1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b1, 1'b1, 16'h0080);
        step();
        checks++; if (imem_addr !== 16'h0002 || instruction !== word(16'h0000) || valid !== 1'b1) begin $display("FAIL stall_taken_hold: got addr=%h %h/%b expected addr=0002 %h/1", imem_addr, instruction, valid, word(16'h0000)); failures++; end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (instruction !== word(16'h0002) || pc !== 16'h0004) begin $display("FAIL stall_taken_next: got %h/%h expected %h/0004", instruction, pc, word(16'h0002)); failures++; end
    endtask

    task automatic test_halt();
        halt_en = 1'b1; halt_addr = 16'h000A;
        do_reset();
        for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 16'h0000); step(); end
        drive(1'b0, 1'b0, 16'h0000);
        checks++; if (imem_addr !== 16'h000A) begin $display("FAIL halt_addr: got %h expected 000a", imem_addr); failures++; end
        step();
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin $display("FAIL halt_state: got halted=%b req=%b expected 1/0", halted, imem_req); failures++; end
        checks++; if (instruction !== 16'hF000 || pc !== 16'h000C || valid !== 1'b1) begin $display("FAIL halt_ifid: got %h/%h/%b expected f000/000c/1", instruction, pc, valid); failures++; end
        lat_random = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'(k), 16'h0040);
            step();
            checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instruction !== 16'hF000) begin $display("FAIL halt_stay[%0d]: got %b/%b/%h expected 1/0/f000", k, halted, imem_req, instruction); failures++; end
        end
        lat_random = 1'b0;
        halt_en = 1'b0;
        do_reset();
        drive(1'b0, 1'b0, 16'h0000);
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin $display("FAIL halt_rst: got %b/%b/%h expected 0/1/0000", halted, imem_req, imem_addr); failures++; end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b0, 1'b1, 16'hFFFC);
        step();
        checks++; if (valid !== 1'b0) begin $display("FAIL wrap_squash: got %b expected 0", valid); failures++; end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (instruction !== word(16'hFFFC) || pc !== 16'hFFFE) begin $display("FAIL wrap_a: got %h/%h expected %h/fffe", instruction, pc, word(16'hFFFC)); failures++; end
        drive(1'b0, 1'b0, 16'h0000);
        step();
        checks++; if (instruction !== word(16'hFFFE) || pc !== 16'h0000) begin $display("FAIL wrap_b: got %h/%h expected %h/0000", instruction, pc, word(16'hFFFE)); failures++; end
        checks++; if (imem_addr !== 16'h0000) begin $display("FAIL wrap_addr: got %h expected 0000", imem_addr); failures++; end
    endtask

    // Stream model: every instruction ID consumes must be the next in program
    // order, or the target of the last branch ID resolved without a stall.
    task automatic test_random();
        logic [15:0] expect_addr;
        logic        s, t, prev_taken;
        logic [15:0] np;
        int          consumed;
        lat_random  = 1'b1;
        do_reset();
        expect_addr = 16'h0000;
        prev_taken  = 1'b0;
        consumed    = 0;
        for (int c = 0; c < 3000; c++) begin
            s  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 5) == 0);
            np = 16'($urandom);
            if ($urandom_range(0, 15) == 0) np = 16'hFFFC;
            if (prev_taken) begin
                checks++; if (valid !== 1'b0) begin $display("FAIL rnd_squash@%0d: got valid=%b expected 0", c, valid); failures++; end
            end
            if (valid === 1'b1 && !s) begin
                checks++; if (pc !== 16'(expect_addr + 16'd2) || instruction !== word(expect_addr)) begin $display("FAIL rnd_stream@%0d: got %h/%h expected %h/%h", c, instruction, pc, word(expect_addr), 16'(expect_addr + 16'd2)); failures++; end
                expect_addr = expect_addr + 16'd2;
                consumed++;
            end
            if (t && !s) expect_addr = np;
            prev_taken = t && !s;
            drive(s, t, np);
            step();
        end
        checks++; if (consumed < 300) begin $display("FAIL rnd_progress: got %0d instructions expected at least 300", consumed); failures++; end
        lat_random = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        stall_in   = 1'b0;
        taken      = 1'b0;
        new_pc     = 16'h0000;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        test_reset();
        test_hits();
        test_miss();
        test_taken_hit();
        test_taken_miss();
        test_stall();
        test_stall_taken();
        test_halt();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
